nexys4_bot_intc: RTL

Interrupt controller/arbiter that shares the single PicoBlaze interrupt line among up to 8 event sources (Rojobot update tick, timers, pushbutton events). It captures rising edges into a pending register, applies a software mask, and picks one winner per interrupt using round-robin priority. It drives the closed-loop interrupt/interrupt_ack handshake and exposes mask/cause/pending/overflow registers on the PicoBlaze port bus. It sits between the event sources and the PicoBlaze core, alongside the I/O interface block.

---
 rtl/nexys4_bot_intc.sv | 135 +++++++++++++
 1 files changed

// File: rtl/nexys4_bot_intc.sv
// Round-robin interrupt controller sharing the PicoBlaze interrupt line among
// NUM_SRC edge-triggered sources, with mask/cause/pending/overflow port registers.
module nexys4_bot_intc #(
  parameter int         NUM_SRC    = 4,
  parameter logic [7:0] MASK_PORT  = 8'h1A,
  parameter logic [7:0] CAUSE_PORT = 8'h1B,
  parameter logic [7:0] EOI_PORT   = 8'h1C,
  parameter logic [7:0] PEND_PORT  = 8'h1D,
  parameter logic [7:0] OVF_PORT   = 8'h1E
) (
  input  logic               sysclk,
  input  logic               sysreset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               write_strobe,
  input  logic               read_strobe,
  input  logic [7:0]         port_id,
  input  logic [7:0]         io_data_in,
  output logic [7:0]         io_data_out,
  output logic               rd_hit,
  output logic               interrupt,
  input  logic               interrupt_ack
);

  typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

  state_t             state_reg;
  logic [NUM_SRC-1:0] src_prev_reg;
  logic [NUM_SRC-1:0] pending_reg;
  logic [NUM_SRC-1:0] edge_det;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] pend_clr;
  logic               armed_reg;
  logic [7:0]         mask_reg;
  logic [7:0]         cause_reg;
  logic [7:0]         ovf_reg;
  logic [2:0]         last_reg;
  logic [2:0]         winner;
  logic               found;
  logic [7:0]         elig8;
  logic [7:0]         clr8;
  logic               ack_take;
  logic               ovf_inc;
  logic               ovf_rd;
  logic               eoi_wr;

  // armed_reg masks the first cycle after reset so sources already high are not seen as edges
  assign edge_det = irq_src & ~src_prev_reg & {NUM_SRC{armed_reg}};
  assign eligible = pending_reg & mask_reg[NUM_SRC-1:0];
  assign elig8    = 8'(eligible);
  assign ack_take = (state_reg == REQ) && interrupt_ack && found;
  assign clr8     = ack_take ? (8'd1 << winner) : 8'd0;
  assign pend_clr = clr8[NUM_SRC-1:0];
  assign ovf_inc  = |(edge_det & pending_reg);
  assign ovf_rd   = read_strobe && (port_id == OVF_PORT);
  assign eoi_wr   = write_strobe && (port_id == EOI_PORT);

  always_comb begin
    winner = 3'd0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      int idx;
      idx = (int'(last_reg) + k) % NUM_SRC;
      if (!found && elig8[3'(idx)]) begin
        found  = 1'b1;
        winner = 3'(idx);
      end
    end
  end

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      state_reg    <= IDLE;
      interrupt    <= 1'b0;
      src_prev_reg <= '0;
      pending_reg  <= '0;
      armed_reg    <= 1'b0;
      mask_reg     <= 8'h00;
      cause_reg    <= 8'h80;
      ovf_reg      <= 8'h00;
      last_reg     <= 3'(NUM_SRC - 1);
    end else begin
      src_prev_reg <= irq_src;
      armed_reg    <= 1'b1;
      // set wins over a same-cycle clear of the same bit
      pending_reg  <= (pending_reg & ~pend_clr) | edge_det;

      if (ovf_rd)
        ovf_reg <= ovf_inc ? 8'h01 : 8'h00;
      else if (ovf_inc && ovf_reg != 8'hFF)
        ovf_reg <= ovf_reg + 8'h01;

      if (write_strobe && port_id == MASK_PORT)
        mask_reg <= io_data_in;

      case (state_reg)
        IDLE: if (|eligible) begin
          interrupt <= 1'b1;
          state_reg <= REQ;
        end
        REQ: if (interrupt_ack) begin
          interrupt <= 1'b0;
          state_reg <= SVC;
          if (found) begin
            cause_reg <= {5'b0, winner};
            last_reg  <= winner;
          end else begin
            cause_reg <= 8'h80;
          end
        end
        SVC: if (eoi_wr) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      io_data_out <= 8'h00;
      rd_hit      <= 1'b0;
    end else begin
      rd_hit <= 1'b1;
      case (port_id)
        MASK_PORT:  io_data_out <= mask_reg;
        CAUSE_PORT: io_data_out <= cause_reg;
        PEND_PORT:  io_data_out <= 8'(pending_reg);
        OVF_PORT:   io_data_out <= ovf_reg;
        default: begin
          io_data_out <= 8'h00;
          rd_hit      <= 1'b0;
        end
      endcase
    end
  end

endmodule
